// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store requester and its lane aligner.
package lsu_pkg;

  localparam int unsigned LaneW     = 8;
  localparam int unsigned WordBytes = 4;
  localparam int unsigned LaneAw    = $clog2(WordBytes);

  typedef enum logic [1:0] {
    SIZE_B    = 2'b00,
    SIZE_H    = 2'b01,
    SIZE_W    = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    LOAD_WAIT = 2'b01,
    RMW_MERGE = 2'b10,
    RESP      = 2'b11
  } state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane alignment: extracts/extends load data and merges sub-word store data
// into a full memory word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [LaneAw-1:0] lane_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [31:0]       rdata_i,
  input  logic [15:0]       wdata_i,
  output logic [31:0]       load_data_c,
  output logic [31:0]       merge_data_c
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] mask;
  logic [31:0] wpos;
  logic        sign;

  always_comb begin
    shamt       = 5'(lane_i * LaneW);
    shifted     = rdata_i >> shamt;
    load_data_c = shifted;
    sign        = 1'b0;
    mask        = '0;
    case (size_e'(size_i))
      SIZE_B: begin
        sign        = ~unsigned_i & shifted[7];
        load_data_c = {{24{sign}}, shifted[7:0]};
        mask        = 32'h0000_00ff << shamt;
      end
      SIZE_H: begin
        sign        = ~unsigned_i & shifted[15];
        load_data_c = {{16{sign}}, shifted[15:0]};
        mask        = 32'h0000_ffff << shamt;
      end
      default: ;
    endcase
    // Only the masked lanes are replaced; the rest keep the freshly read word.
    wpos         = 32'(wdata_i) << shamt;
    merge_data_c = (rdata_i & ~mask) | (wpos & mask);
  end

endmodule

// File: rtl/mem_lsu_rmw.sv
// Load/store requester for a single-port sync-read word memory; sub-word stores
// are done as read-modify-write, bad accesses are flagged without touching memory.
module mem_lsu_rmw
  import lsu_pkg::*;
#(
  parameter  int unsigned NumEntries = 31,
  parameter  int unsigned AddrWidth  = 32,
  localparam int unsigned MemAw      = $clog2(NumEntries)
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [1:0]           req_size_i,
  input  logic                 req_unsigned_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [31:0]          req_wdata_i,
  output logic                 resp_valid_o,
  output logic [31:0]          resp_rdata_o,
  output logic                 resp_err_o,
  output logic                 mem_rd_valid_o,
  output logic [MemAw-1:0]     mem_rd_addr_o,
  input  logic [31:0]          mem_rd_data_i,
  output logic                 mem_wr_valid_o,
  output logic [MemAw-1:0]     mem_wr_addr_o,
  output logic [31:0]          mem_wr_data_o
);

  state_e              state_q, state_d;
  size_e               size_q, size_d;
  logic                unsigned_q, unsigned_d;
  logic [LaneAw-1:0]   lane_q, lane_d;
  logic [MemAw-1:0]    idx_q, idx_d;
  logic [15:0]         wdata_q, wdata_d;
  logic                err_q, err_d;

  logic [MemAw-1:0]    req_idx;
  logic [LaneAw-1:0]   req_lane;
  size_e               req_size;
  logic                req_err;
  logic [31:0]         load_data;
  logic [31:0]         merge_data;

  // Request address decode and access legality.
  always_comb begin
    req_idx  = req_addr_i[MemAw+1:2];
    req_lane = req_addr_i[LaneAw-1:0];
    req_size = size_e'(req_size_i);
    req_err  = (req_size == SIZE_RSVD)
             | ((req_size == SIZE_H) & req_addr_i[0])
             | ((req_size == SIZE_W) & (|req_addr_i[LaneAw-1:0]))
             | (32'(req_idx) >= NumEntries)
             | (|req_addr_i[AddrWidth-1:MemAw+2]);
  end

  lsu_lane_align u_align (
    .lane_i       (lane_q),
    .size_i       (size_q),
    .unsigned_i   (unsigned_q),
    .rdata_i      (mem_rd_data_i),
    .wdata_i      (wdata_q),
    .load_data_c  (load_data),
    .merge_data_c (merge_data)
  );

  always_comb begin
    state_d        = state_q;
    size_d         = size_q;
    unsigned_d     = unsigned_q;
    lane_d         = lane_q;
    idx_d          = idx_q;
    wdata_d        = wdata_q;
    err_d          = err_q;
    req_ready_o    = 1'b0;
    resp_valid_o   = 1'b0;
    resp_rdata_o   = '0;
    resp_err_o     = 1'b0;
    mem_rd_valid_o = 1'b0;
    mem_rd_addr_o  = req_idx;
    mem_wr_valid_o = 1'b0;
    mem_wr_addr_o  = idx_q;
    mem_wr_data_o  = merge_data;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          size_d     = req_size;
          unsigned_d = req_unsigned_i;
          lane_d     = req_lane;
          idx_d      = req_idx;
          wdata_d    = req_wdata_i[15:0];
          err_d      = req_err;
          if (req_err) begin
            state_d = RESP;
          end else if (!req_we_i) begin
            mem_rd_valid_o = 1'b1;
            state_d        = LOAD_WAIT;
          end else if (req_size == SIZE_W) begin
            mem_wr_valid_o = 1'b1;
            mem_wr_addr_o  = req_idx;
            mem_wr_data_o  = req_wdata_i;
            state_d        = RESP;
          end else begin
            // Sub-word store: fetch the word first, merge next cycle.
            mem_rd_valid_o = 1'b1;
            state_d        = RMW_MERGE;
          end
        end
      end
      LOAD_WAIT: begin
        resp_valid_o = 1'b1;
        resp_rdata_o = load_data;
        state_d      = IDLE;
      end
      RMW_MERGE: begin
        mem_wr_valid_o = 1'b1;
        state_d        = RESP;
      end
      RESP: begin
        resp_valid_o = 1'b1;
        resp_err_o   = err_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= IDLE;
      size_q     <= SIZE_B;
      unsigned_q <= 1'b0;
      lane_q     <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      lane_q     <= lane_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_lsu_rmw.sv
// Self-checking bench for mem_lsu_rmw: directed scenarios plus randomized traffic
// against a byte-level reference memory model.
module tb_mem_lsu_rmw;

  localparam int unsigned NumEnt = 31;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        mem_rd_valid_o;
  logic [4:0]  mem_rd_addr_o;
  logic [31:0] mem_rd_data_i;
  logic        mem_wr_valid_o;
  logic [4:0]  mem_wr_addr_o;
  logic [31:0] mem_wr_data_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem     [32];
  logic [31:0] ref_mem [32];
  logic        preload;

  always #5 clk_i = ~clk_i;

  mem_lsu_rmw #(.NumEntries(31), .AddrWidth(32)) dut (
    .clk_i          (clk_i),
    .reset_ni       (reset_ni),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .resp_valid_o   (resp_valid_o),
    .resp_rdata_o   (resp_rdata_o),
    .resp_err_o     (resp_err_o),
    .mem_rd_valid_o (mem_rd_valid_o),
    .mem_rd_addr_o  (mem_rd_addr_o),
    .mem_rd_data_i  (mem_rd_data_i),
    .mem_wr_valid_o (mem_wr_valid_o),
    .mem_wr_addr_o  (mem_wr_addr_o),
    .mem_wr_data_o  (mem_wr_data_o)
  );

  // Single-port synchronous-read memory; contents survive DUT reset.
  always @(posedge clk_i) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= ref_mem[i];
    end else begin
      if (mem_rd_valid_o) mem_rd_data_i <= mem[mem_rd_addr_o];
      if (mem_wr_valid_o) mem[mem_wr_addr_o] <= mem_wr_data_o;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (reset_ni) check_eq("rd_wr_excl", 32'(mem_rd_valid_o & mem_wr_valid_o), 32'd0);
  end

  // Reference behaviour from the access rules, in byte-address arithmetic.
  task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic exp_err, output logic [31:0] exp_rdata,
                       output int exp_lat, output int exp_rd, output int exp_wr);
    int unsigned idx, ln;
    logic [31:0] word, v, mask;
    idx       = addr / 4;
    ln        = addr % 4;
    exp_err   = (sz == 2'd3) || (sz == 2'd1 && (addr % 2) != 0) ||
                (sz == 2'd2 && ln != 0) || (addr >= 4 * NumEnt);
    exp_rdata = 32'd0;
    exp_lat   = 1;
    exp_rd    = 0;
    exp_wr    = 0;
    if (exp_err) return;
    if (!we) begin
      exp_rd = 1;
      word   = ref_mem[idx];
      if (sz == 2'd0) begin
        v = (word >> (8 * ln)) & 32'hff;
        if (!uns && v >= 128) v = v + 32'hffff_ff00;
      end else if (sz == 2'd1) begin
        v = (word >> (8 * ln)) & 32'hffff;
        if (!uns && v >= 32768) v = v + 32'hffff_0000;
      end else begin
        v = word;
      end
      exp_rdata = v;
    end else if (sz == 2'd2) begin
      exp_wr       = 1;
      ref_mem[idx] = wd;
    end else begin
      exp_rd       = 1;
      exp_wr       = 1;
      exp_lat      = 2;
      mask         = ((sz == 2'd0) ? 32'hff : 32'hffff) << (8 * ln);
      ref_mem[idx] = (ref_mem[idx] & ~mask) | ((wd << (8 * ln)) & mask);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] o_rdata, output logic o_err);
    logic        e_err;
    logic [31:0] e_rdata;
    int          e_lat, e_rd, e_wr, lat, rd_cnt, wr_cnt, guard;
    bit          got;
    model(we, sz, uns, addr, wd, e_err, e_rdata, e_lat, e_rd, e_wr);
    @(negedge clk_i);
    guard = 0;
    while (!req_ready_o && guard < 10) begin
      @(negedge clk_i);
      guard++;
    end
    check_eq("ready_at_issue", 32'(req_ready_o), 32'd1);
    req_valid_i    = 1'b1;
    req_we_i       = we;
    req_size_i     = sz;
    req_unsigned_i = uns;
    req_addr_i     = addr;
    req_wdata_i    = wd;
    #1;
    rd_cnt = int'(mem_rd_valid_o);
    wr_cnt = int'(mem_wr_valid_o);
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    req_addr_i  = $urandom;
    req_wdata_i = $urandom;
    lat     = 0;
    got     = 1'b0;
    o_rdata = 32'hx;
    o_err   = 1'bx;
    while (!got && lat < 5) begin
      @(negedge clk_i);
      lat++;
      rd_cnt += int'(mem_rd_valid_o);
      wr_cnt += int'(mem_wr_valid_o);
      if (resp_valid_o) begin
        got     = 1'b1;
        o_rdata = resp_rdata_o;
        o_err   = resp_err_o;
      end
    end
    check_eq("resp_seen", 32'(got), 32'd1);
    check_eq("latency", 32'(lat), 32'(e_lat));
    check_eq("err", 32'(o_err), 32'(e_err));
    check_eq("rdata", o_rdata, e_rdata);
    check_eq("rd_strobes", 32'(rd_cnt), 32'(e_rd));
    check_eq("wr_strobes", 32'(wr_cnt), 32'(e_wr));
    @(negedge clk_i);
    check_eq("resp_one_cycle", 32'(resp_valid_o), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd, a, w, e_rd2;
    logic        er, e_er2, uns;
    logic [1:0]  sz;
    int          e_l2, e_r2, e_w2, r;

    for (int i = 0; i < 32; i++) ref_mem[i] = $urandom;
    ref_mem[3]     = 32'h80ff_7f01;
    reset_ni       = 1'b0;
    preload        = 1'b1;
    req_valid_i    = 1'b0;
    req_we_i       = 1'b0;
    req_size_i     = 2'd0;
    req_unsigned_i = 1'b0;
    req_addr_i     = '0;
    req_wdata_i    = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("rst_ready", 32'(req_ready_o), 32'd1);
    check_eq("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    check_eq("rst_rdata", resp_rdata_o, 32'd0);
    check_eq("rst_err", 32'(resp_err_o), 32'd0);
    check_eq("rst_strobes", 32'({mem_rd_valid_o, mem_wr_valid_o}), 32'd0);
    preload  = 1'b0;
    reset_ni = 1'b1;

    do_req(1'b0, 2'd0, 1'b0, 32'h0d, 32'd0, rd, er);
    check_eq("tp_lb_0d", rd, 32'h0000_007f);
    do_req(1'b0, 2'd0, 1'b0, 32'h0e, 32'd0, rd, er);
    check_eq("tp_lb_0e", rd, 32'hffff_ffff);
    do_req(1'b0, 2'd0, 1'b1, 32'h0e, 32'd0, rd, er);
    check_eq("tp_lbu_0e", rd, 32'h0000_00ff);
    do_req(1'b0, 2'd1, 1'b0, 32'h0e, 32'd0, rd, er);
    check_eq("tp_lh_0e", rd, 32'hffff_80ff);
    do_req(1'b0, 2'd1, 1'b1, 32'h0e, 32'd0, rd, er);
    check_eq("tp_lhu_0e", rd, 32'h0000_80ff);
    do_req(1'b0, 2'd1, 1'b0, 32'h0d, 32'd0, rd, er);
    check_eq("tp_lh_mis_err", 32'(er), 32'd1);
    do_req(1'b1, 2'd0, 1'b0, 32'h0d, 32'h0000_00ab, rd, er);
    do_req(1'b0, 2'd2, 1'b0, 32'h0c, 32'd0, rd, er);
    check_eq("tp_lw_after_sb", rd, 32'h80ff_ab01);
    do_req(1'b1, 2'd2, 1'b0, 32'h78, 32'hdead_beef, rd, er);
    check_eq("tp_sw_idx30_err", 32'(er), 32'd0);
    do_req(1'b1, 2'd2, 1'b0, 32'h7c, 32'h1234_5678, rd, er);
    check_eq("tp_sw_idx31_err", 32'(er), 32'd1);

    // Back-to-back loads with valid held high.
    @(negedge clk_i);
    req_valid_i    = 1'b1;
    req_we_i       = 1'b0;
    req_size_i     = 2'd2;
    req_unsigned_i = 1'b0;
    req_addr_i     = 32'h0c;
    @(negedge clk_i);
    check_eq("b2b_ready_low", 32'(req_ready_o), 32'd0);
    check_eq("b2b_resp1_valid", 32'(resp_valid_o), 32'd1);
    check_eq("b2b_resp1_data", resp_rdata_o, ref_mem[3]);
    check_eq("b2b_no_rd_busy", 32'(mem_rd_valid_o), 32'd0);
    req_size_i     = 2'd0;
    req_unsigned_i = 1'b1;
    req_addr_i     = 32'h0f;
    model(1'b0, 2'd0, 1'b1, 32'h0f, 32'd0, e_er2, e_rd2, e_l2, e_r2, e_w2);
    @(negedge clk_i);
    check_eq("b2b_ready_again", 32'(req_ready_o), 32'd1);
    check_eq("b2b_rd2_issued", 32'(mem_rd_valid_o), 32'd1);
    check_eq("b2b_no_resp_gap", 32'(resp_valid_o), 32'd0);
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    @(negedge clk_i);
    check_eq("b2b_resp2_valid", 32'(resp_valid_o), 32'd1);
    check_eq("b2b_resp2_data", resp_rdata_o, e_rd2);

    // Reset while the merge write is pending.
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_we_i    = 1'b1;
    req_size_i  = 2'd0;
    req_addr_i  = 32'h0e;
    req_wdata_i = 32'h77;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    check_eq("rst_mid_in_merge", 32'(mem_wr_valid_o), 32'd1);
    reset_ni = 1'b0;
    #1;
    check_eq("rst_mid_no_wr", 32'(mem_wr_valid_o), 32'd0);
    check_eq("rst_mid_no_resp", 32'(resp_valid_o), 32'd0);
    @(negedge clk_i);
    check_eq("rst_mid_no_wr2", 32'(mem_wr_valid_o), 32'd0);
    @(negedge clk_i);
    reset_ni = 1'b1;
    #1;
    check_eq("rst_mid_ready", 32'(req_ready_o), 32'd1);
    check_eq("rst_mid_no_resp2", 32'(resp_valid_o), 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h0c, 32'd0, rd, er);
    check_eq("rst_mid_word_kept", rd, 32'h80ff_ab01);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      a = $urandom;
      else if (r == 1) a = 32'(4 * NumEnt) + $urandom_range(0, 3);
      else             a = $urandom_range(0, 4 * NumEnt - 1);
      r = int'($urandom_range(0, 7));
      if (r <= 2)      sz = 2'd0;
      else if (r <= 4) sz = 2'd1;
      else if (r <= 6) sz = 2'd2;
      else             sz = 2'd3;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a = a & ~32'd1;
        if (sz == 2'd2) a = a & ~32'd3;
      end
      uns = 1'($urandom_range(0, 1));
      w   = $urandom;
      do_req(1'($urandom_range(0, 1)), sz, uns, a, w, rd, er);
    end

    @(negedge clk_i);
    for (int i = 0; i < int'(NumEnt); i++) check_eq($sformatf("mem_final_%0d", i), mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_lsu_rmw.md
Name: mem_lsu_rmw

Overview:
Load/store requester that drives a single-port synchronous-read word memory (1-cycle read latency, no byte enables) on behalf of the pipeline MEM stage. It converts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses. Sub-word stores are performed as a read-modify-write sequence. The block returns sign- or zero-extended load data, and flags misaligned or out-of-range accesses instead of touching memory.

Parameters:
NumEntries, 31, memory depth in 32-bit words; memory word-address width MemAw = $clog2(NumEntries).
AddrWidth, 32, byte address width of the request.

Ports:
clk_i  in  1  clock.
reset_ni  in  1  asynchronous active-low reset.
req_valid_i  in  1  request valid.
req_ready_o  out  1  block idle and able to accept.
req_we_i  in  1  1 = store, 0 = load.
req_size_i  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
req_unsigned_i  in  1  zero-extend load data (LBU/LHU).
req_addr_i  in  AddrWidth  byte address.
req_wdata_i  in  32  store data, right-aligned.
resp_valid_o  out  1  one-cycle response pulse.
resp_rdata_o  out  32  extended load data; 0 for stores and errors.
resp_err_o  out  1  misaligned, reserved size, or out-of-range access.
mem_rd_valid_o  out  1  memory read strobe.
mem_rd_addr_o  out  MemAw  memory read word address.
mem_rd_data_i  in  32  memory read data, valid the cycle after the strobe.
mem_wr_valid_o  out  1  memory write strobe.
mem_wr_addr_o  out  MemAw  memory write word address.
mem_wr_data_o  out  32  memory write data.

Behaviour:
- Clock/reset: one clock; reset is asynchronous, active-low.
- Reset values: state IDLE; req_ready_o=1; resp_valid_o=0; resp_rdata_o=0; resp_err_o=0; all mem strobes 0. Captured request registers reset to 0.
- Address decode:
  - word index = req_addr_i[MemAw+1:2]; byte lane = req_addr_i[1:0].
  - Error if any of: size=11; half access with addr[0]=1; word access with addr[1:0]!=0; word index >= NumEntries; any address bit above MemAw+1 set.
- States:
  - IDLE: ready=1. Accept on req_valid_i. Capture we, size, unsigned, lane, index, wdata.
  - Error on accept: no memory strobe; go to RESP with err=1.
  - Load on accept: mem_rd_valid_o=1 combinationally in the accept cycle with mem_rd_addr_o=index; go to LOAD_WAIT.
  - Word store on accept: mem_wr_valid_o=1 in the accept cycle with data=wdata; go to RESP.
  - Byte/half store on accept: issue read as for a load; go to RMW_MERGE.
  - LOAD_WAIT: sample mem_rd_data_i and shift right by lane*8. Byte: extend bit 7; half: extend bit 15; word: pass through. Sign- or zero-extend per unsigned flag. Assert resp_valid_o this cycle (combinational from mem_rd_data_i); then IDLE. Load latency is 1 cycle after accept.
  - RMW_MERGE: replace the selected byte (or half at lanes 0/2) of mem_rd_data_i with wdata[7:0] (or wdata[15:0]). Issue mem_wr_valid_o with the merged word to the same index; go to RESP.
  - RESP: resp_valid_o=1 for exactly one cycle, resp_rdata_o=0, err as captured; then IDLE.
- Latency:
  - Load: 1 cycle after accept.
  - Word store and error: 1 cycle after accept.
  - Sub-word store: 2 cycles after accept.
  - Throughput: at most one request per 2 cycles (ready=0 outside IDLE).
- No response backpressure: the consumer must take resp_valid_o.
- mem_rd_data_i is only sampled in the cycle after this block's own read strobe; it is held stale otherwise and is ignored.
- Never assert mem_rd_valid_o and mem_wr_valid_o in the same cycle.
- Mid-operation reset: return to IDLE immediately. Abandon any in-flight RMW (no write issued) and emit no response.
- Request inputs are ignored while ready=0.

Decomposition:
- Package lsu_pkg:
  - size enum: SIZE_B, SIZE_H, SIZE_W, SIZE_RSVD.
  - state enum: IDLE, LOAD_WAIT, RMW_MERGE, RESP.
  - Constants: lane width 8, word bytes 4.
- One combinational sub-module, lsu_lane_align: load extract/extend plus store merge, given lane, size, and unsigned. The FSM and address/error decode remain in the top level.

Test Plan:
- Preload word 3 = 0x80FF_7F01. LB addr 0x0D -> resp after 1 cycle, rdata=0x0000_007F. LB addr 0x0E -> 0xFFFF_FFFF. LBU addr 0x0E -> 0x0000_00FF.
- LH addr 0x0E on word 3 -> 0xFFFF_80FF. LHU -> 0x0000_80FF. LH addr 0x0D -> err=1, no mem strobe seen.
- SB wdata 0xAB at addr 0x0D on word 3 -> read strobe, then write 0x80FF_AB01 the next cycle, resp at cycle 2. A subsequent LW returns 0x80FF_AB01.
- SW 0xDEAD_BEEF at addr 0x78 (index 30) -> single write, resp next cycle. SW at addr 0x7C (index 31 >= NumEntries) -> err=1, no write.
- Back-to-back req_valid_i held high for two loads -> ready low in LOAD_WAIT, second accepted 2 cycles after the first, both responses correct.
- Assert reset_ni low during RMW_MERGE -> no mem_wr_valid_o, no resp_valid_o, ready=1 after release; target word unchanged.
